// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes used by the control decoder and the
// multicycle ALU, plus the ALU sequencing states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_MUL   = 3'b010,
        ALU_AND   = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SL    = 3'b101,
        ALU_SR    = 3'b110,
        ALU_WRONG = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Shift amount is always taken from the low bits of operand B.
    localparam int SHAMT_W = 5;

    function automatic logic is_mul(input logic [2:0] code);
        return code == ALU_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: load captures operands, each step adds one
// partial product; last_o flags the final step so the caller can grab product_o.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] product_o,
    output logic             last_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;

    // product_o is the accumulator including the current step, so the value
    // is complete in the same cycle last_o is high.
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o = acc_d;
    assign last_o    = step_i && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith ops, WIDTH-cycle iterative multiply,
// registered result with done/err pulses.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o
);

    alu_state_e       state_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0]   comb_res;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               mul_load;
    logic               mul_step;
    logic               mul_last;
    logic [WIDTH-1:0]   mul_product;

    assign shamt    = data2_i[SHAMT_W-1:0];
    assign accept   = start_i && (state_q != ST_MUL);
    assign mul_load = accept && is_mul(ctrl_i);
    assign mul_step = (state_q == ST_MUL);

    always_comb begin
        comb_res = '0;
        case (alu_op_e'(ctrl_i))
            ALU_ADD: comb_res = data1_i + data2_i;
            ALU_SUB: comb_res = data1_i - data2_i;
            ALU_AND: comb_res = data1_i & data2_i;
            ALU_XOR: comb_res = data1_i ^ data2_i;
            ALU_SL:  comb_res = data1_i << shamt;
            ALU_SR:  comb_res = $unsigned($signed(data1_i) >>> shamt);
            default: comb_res = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .a_i       (data1_i),
        .b_i       (data2_i),
        .product_o (mul_product),
        .last_o    (mul_last)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_MUL: begin
                    if (mul_last) begin
                        state_q  <= ST_DONE;
                        result_q <= mul_product;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE lasts one cycle at most.
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (!accept) begin
                        state_q <= ST_IDLE;
                    end else if (is_mul(ctrl_i)) begin
                        state_q <= ST_MUL;
                    end else begin
                        state_q  <= ST_DONE;
                        result_q <= comb_res;
                        done_q   <= 1'b1;
                        err_q    <= (ctrl_i == ALU_WRONG);
                    end
                end
            endcase
        end
    end

    assign busy_o   = (state_q == ST_MUL);
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expected results are queued at issue
// time and popped when done_o is seen.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk_i   = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         start_i = 1'b0;
    logic [2:0]   ctrl_i  = 3'd0;
    logic [W-1:0] data1_i = '0;
    logic [W-1:0] data2_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         err_o;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return a & b;
            3'd4:    return a ^ b;
            3'd5:    return a << sh;
            3'd6:    return $unsigned($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    // Drive one accepted op and queue its expectation; returns #1 after the
    // acceptance edge with inputs scrambled to test operand capture.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic err);
        exp_t e;
        @(negedge clk_i);
        start_i = 1'b1;
        ctrl_i  = op;
        data1_i = a;
        data2_i = b;
        e.res = res;
        e.err = err;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        ctrl_i  = 3'($urandom);
        data1_i = $urandom;
        data2_i = $urandom;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (done_o !== 1'b1 && lat < 200) begin
            if (busy_o === 1'b1) busy_cnt++;
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err_o); end
        total++; if (result_o !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        $display("reset released");
    endtask

    task automatic test_add();
        int lat, bc;
        exp_t e;
        issue(3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        wait_done(lat, bc);
        e = sb.pop_front();
        total++; if (lat != 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
        total++; if (bc != 0 || busy_o !== 1'b0) begin bad++; $display("FAIL add_busy got=%0d want=0", bc); end
        total++; if (result_o !== e.res) begin bad++; $display("FAIL add_result got=%h want=%h", result_o, e.res); end
        total++; if (err_o !== e.err) begin bad++; $display("FAIL add_err got=%0b want=%0b", err_o, e.err); end
        @(posedge clk_i); #1;
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%0b want=0", done_o); end
        $display("ADD ffffffff+1 -> %h lat=%0d", result_o, lat);
    endtask

    task automatic test_shifts();
        int lat, bc;
        exp_t e;
        issue(3'd6, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0);
        wait_done(lat, bc);
        e = sb.pop_front();
        total++; if (result_o !== e.res || lat != 1) begin bad++; $display("FAIL sr_result got=%h lat=%0d want=%h lat=1", result_o, lat, e.res); end
        $display("SR 80000000>>>0x24 -> %h", result_o);
        issue(3'd5, 32'h1, 32'd31, 32'h8000_0000, 1'b0);
        wait_done(lat, bc);
        e = sb.pop_front();
        total++; if (result_o !== e.res || lat != 1) begin bad++; $display("FAIL sl_result got=%h lat=%0d want=%h lat=1", result_o, lat, e.res); end
        $display("SL 1<<31 -> %h", result_o);
    endtask

    task automatic test_mul();
        int lat, bc, dones;
        exp_t e;
        issue(3'd2, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0);
        lat = 1;
        bc = 0;
        while (done_o !== 1'b1 && lat < 200) begin
            if (busy_o === 1'b1) bc++;
            // Try to start an ADD mid-multiply; it must be dropped.
            if (lat == 10) begin start_i = 1'b1; ctrl_i = 3'd0; data1_i = 32'd1; data2_i = 32'd2; end
            if (lat == 11) start_i = 1'b0;
            @(posedge clk_i);
            #1;
            lat++;
        end
        e = sb.pop_front();
        total++; if (lat != 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
        total++; if (bc != 32) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=32", bc); end
        total++; if (result_o !== e.res) begin bad++; $display("FAIL mul_result got=%h want=%h", result_o, e.res); end
        dones = 0;
        repeat (5) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) dones++;
        end
        total++; if (dones != 0 || result_o !== e.res) begin bad++; $display("FAIL mul_ignored_start got dones=%0d res=%h want dones=0 res=%h", dones, result_o, e.res); end
        $display("MUL fffffffd*7 -> %h lat=%0d busy=%0d", result_o, lat, bc);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk_i);
        start_i = 1'b1; ctrl_i = 3'd4; data1_i = 32'hF0F0_F0F0; data2_i = 32'hFF00_FF00;
        sb.push_back('{32'h0FF0_0FF0, 1'b0});
        @(posedge clk_i); #1;
        ctrl_i = 3'd3;
        sb.push_back('{32'hF000_F000, 1'b0});
        e = sb.pop_front();
        total++; if (done_o !== 1'b1 || result_o !== e.res) begin bad++; $display("FAIL b2b_xor got done=%0b res=%h want done=1 res=%h", done_o, result_o, e.res); end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        e = sb.pop_front();
        total++; if (done_o !== 1'b1 || result_o !== e.res) begin bad++; $display("FAIL b2b_and got done=%0b res=%h want done=1 res=%h", done_o, result_o, e.res); end
        @(posedge clk_i); #1;
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0b want=0", done_o); end
        $display("XOR/AND back-to-back -> %h", result_o);
    endtask

    task automatic test_wrong();
        int lat, bc;
        exp_t e;
        issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1);
        wait_done(lat, bc);
        e = sb.pop_front();
        total++; if (lat != 1 || err_o !== e.err || result_o !== e.res) begin bad++; $display("FAIL wrong_op got lat=%0d err=%0b res=%h want lat=1 err=1 res=0", lat, err_o, result_o); end
        @(posedge clk_i); #1;
        total++; if (err_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL wrong_pulse got err=%0b done=%0b want 0 0", err_o, done_o); end
        $display("WRONG -> err=1 res=0 lat=%0d", lat);
    endtask

    task automatic test_random();
        int lat, bc;
        exp_t e;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            issue(op, a, b, model(op, a, b), op == 3'd7);
            wait_done(lat, bc);
            e = sb.pop_front();
            total++;
            if (result_o !== e.res || err_o !== e.err || lat != ((op == 3'd2) ? 33 : 1)) begin
                bad++;
                $display("FAIL rand_%0d op=%0d got res=%h err=%0b lat=%0d want res=%h err=%0b", i, op, result_o, err_o, lat, e.res, e.err);
            end
            $display("rand op=%0d a=%h b=%h -> %h", op, a, b, result_o);
        end
    endtask

    task automatic test_reset_mid_mul();
        int   lat, spurious;
        exp_t e;
        issue(3'd2, 32'd12345, 32'd678, 32'd12345 * 32'd678, 1'b0);
        lat = 1;
        while (lat < 10) begin @(posedge clk_i); #1; lat++; end
        #2;
        rst_n_i = 1'b0;
        #1;
        e = sb.pop_back();
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || result_o !== '0) begin
            bad++;
            $display("FAIL rst_async got busy=%0b done=%0b err=%0b res=%h want all 0", busy_o, done_o, err_o, result_o);
        end
        spurious = 0;
        repeat (3) begin @(posedge clk_i); #1; if (done_o !== 1'b0 || busy_o !== 1'b0) spurious++; end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        start_i = 1'b1; ctrl_i = 3'd0; data1_i = 32'd5; data2_i = 32'd7;
        sb.push_back('{32'd12, 1'b0});
        @(posedge clk_i); #1;
        start_i = 1'b0;
        e = sb.pop_front();
        total++; if (done_o !== 1'b1 || result_o !== e.res) begin bad++; $display("FAIL rst_then_add got done=%0b res=%h want done=1 res=%h", done_o, result_o, e.res); end
        repeat (40) begin @(posedge clk_i); #1; if (done_o !== 1'b0) spurious++; end
        total++; if (spurious != 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", spurious); end
        $display("reset mid-MUL then ADD 5+7 -> %h", result_o);
    endtask

    initial begin
        test_reset();
        test_add();
        test_shifts();
        test_mul();
        test_back_to_back();
        test_wrong();
        test_random();
        test_reset_mid_mul();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_empty got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have port clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start_i  input  1  request to start an operation.
REQ-005 The block SHALL have port ctrl_i  input  3  operation code, as produced by the ALU control decoder.
REQ-006 The block SHALL have port data1_i  input  WIDTH  operand A (rs1).
REQ-007 The block SHALL have port data2_i  input  WIDTH  operand B (rs2 or immediate).
REQ-008 The block SHALL have port busy_o  output  1  high while a multiply is iterating; start_i is ignored when high.
REQ-009 The block SHALL have port done_o  output  1  one-cycle pulse marking result_o valid.
REQ-010 The block SHALL have port result_o  output  WIDTH  registered result, held until the next accepted operation completes.
REQ-011 The block SHALL have port err_o  output  1  one-cycle pulse, coincident with done_o, for an illegal code.

Function
REQ-012 Op codes SHALL be ADD=000, SUB=001, MUL=010, AND=011, XOR=100, SL=101, SR=110, WRONG=111.
REQ-013 State machine SHALL be IDLE, MUL, DONE; an operation is accepted on a rising edge where start_i=1 and state is IDLE or DONE.
REQ-014 Operands and ctrl_i SHALL be captured at acceptance; later input changes do not affect the operation in flight.
REQ-015 A non-MUL op accepted at edge N SHALL go to DONE, with result_o updated and done_o=1 during the cycle after edge N (latency 1).
REQ-016 MUL SHALL enter state MUL with a 5-bit iteration counter at 0, perform one shift-add step per cycle for WIDTH cycles, then go to DONE; done_o rises WIDTH+1 cycles after acceptance (33 for WIDTH=32).
REQ-017 busy_o SHALL equal (state==MUL); start_i while busy_o=1 SHALL be ignored with no queueing.
REQ-018 DONE SHALL last exactly one cycle, then go to IDLE, or go directly to the new op if start_i=1 (back-to-back throughput: one non-MUL op per cycle).
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-020 MUL SHALL return the low WIDTH bits of the product; the result is identical for signed and unsigned operands.
REQ-021 AND and XOR SHALL be bitwise.
REQ-022 SL SHALL shift left logical by data2_i[4:0]; SR SHALL shift right arithmetic (sign-filling) by data2_i[4:0]; upper bits of data2_i SHALL be ignored.
REQ-023 WRONG SHALL produce result_o=0 and err_o=1 for the done cycle, latency 1.
REQ-024 done_o and err_o SHALL be low in every state other than DONE.

Reset
REQ-025 Assertion of rst_n_i SHALL immediately force state=IDLE, counter=0, busy_o=0, done_o=0, err_o=0 and result_o=0, including during a MUL iteration.
REQ-026 An operation aborted by reset SHALL produce no done_o; the first edge after deassertion SHALL be able to accept start_i.

Structure
REQ-027 Op-code constants (ADD..WRONG) SHALL live in shared package alu_pkg, used by both this block and the ALU control decoder.
REQ-028 The iterative multiplier SHALL be a sub-module alu_mul_iter (load, step, and counter-done interface); all other ops are inline combinational logic feeding the result register.

Verification
REQ-029 The bench SHALL apply ADD, A=0xFFFFFFFF, B=1 -> result_o=0x00000000, done_o high on the 1st cycle after acceptance, busy_o never high.
REQ-030 The bench SHALL apply SR, A=0x80000000, B=0x00000024 -> result_o=0xF8000000 (shift 4; bit 5 of B ignored); SL with A=1, B=31 -> result_o=0x80000000.
REQ-031 The bench SHALL apply MUL, A=0xFFFFFFFD (-3), B=7 -> result_o=0xFFFFFFEB at acceptance+33, busy_o high for 32 cycles, and a start_i pulse mid-multiply is ignored.
REQ-032 The bench SHALL apply back-to-back XOR then AND, starting in consecutive cycles (A=0xF0F0F0F0, B=0xFF00FF00) -> done_o high for 2 consecutive cycles, with results 0x0FF00FF0 then 0xF000F000.
REQ-033 The bench SHALL apply ctrl_i=111 -> done_o=1, err_o=1, result_o=0 for one cycle.
REQ-034 The bench SHALL assert rst_n_i low at MUL iteration 10 -> all outputs become 0 without waiting for a clock edge, no done_o follows, and an ADD accepted right after release completes normally.
